cla_seq_addsub: RTL

CLA_SEQ_ADDSUB -- requirements
Module: cla_seq_addsub

---
 rtl/cla_seq_addsub.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cla_seq_addsub.sv
// Sequential adder/subtractor: one 4-bit carry-lookahead slice per cycle,
// walking the operand nibbles LSB first. Results hold until the next completion.
module cla_seq_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [IW+1:0]    bofs;
  logic [3:0]       na, nb, g, p, s;
  logic [4:0]       c;

  // Carry-lookahead slice on the nibble selected by idx_q
  always_comb begin
    bofs = {idx_q, 2'b00};
    na   = opa_q[bofs +: 4];
    nb   = opb_q[bofs +: 4];
    g    = na & nb;
    p    = na ^ nb;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = p ^ c[3:0];
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    work_d   = work_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          work_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        work_d[bofs +: 4] = s;
        carry_d           = c[4];
        if (idx_q == IW'(NIB - 1)) begin
          // Final nibble: its internal carries give the sign-bit overflow
          idx_d    = '0;
          result_d = work_d;
          c_out_d  = c[4];
          ovf_d    = c[3] ^ c[4];
          zero_d   = (work_d == '0);
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      work_q   <= work_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule
